// File: rtl/arb_req_shim.sv
// arb_req_shim: per-port request bookkeeping in front of a one-hot
// fixed-priority arbiter. Each port counts pending requests, raises req_o
// while work is pending, pulses done_o on a legal grant, and tracks wait
// time for starvation. Illegal grant vectors are ignored and flagged.

module arb_req_shim_port #(
  parameter int MAX_PEND     = 3,
  parameter int STARVE_LIMIT = 8,
  parameter int PW           = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          legal_i,
  output logic          req_o,
  output logic          done_o,
  output logic          starve_o,
  output logic          ovf_o,
  output logic [PW-1:0] pend_o
);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PEND);
  localparam logic [7:0]    SLIM = 8'(STARVE_LIMIT);

  logic [PW-1:0] pend_q, pend_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          done_q, ovf_q, ovf_d;

  assign req_o    = (pend_q != '0);
  assign done_o   = done_q;
  assign starve_o = (wcnt_q >= SLIM);
  assign ovf_o    = ovf_q;
  assign pend_o   = pend_q;

  // Next pending count / overflow: grant+push cancel, a full port drops pushes.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (legal_i) begin
      if (!push_i) pend_d = pend_q - 1'b1;
    end else if (push_i) begin
      if (pend_q < MAXP) pend_d = pend_q + 1'b1;
      else               ovf_d  = 1'b1;
    end
  end

  // Wait counter: counts ungranted requesting cycles, saturates at 255.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!req_o || legal_i)    wcnt_d = '0;
    else if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
  end

  // Port state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      wcnt_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      wcnt_q <= wcnt_d;
      done_q <= legal_i;
      ovf_q  <= ovf_d;
    end
  end
endmodule

module arb_req_shim #(
  parameter int NUM_PORTS    = 4,
  parameter int MAX_PEND     = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] push_i,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic [NUM_PORTS-1:0] req_o,
  output logic [NUM_PORTS-1:0] done_o,
  output logic [NUM_PORTS-1:0] starve_o,
  output logic [NUM_PORTS-1:0] ovf_o,
  output logic                 gnt_err_o
);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic                          legal_any, gnt_bad;
  logic [NUM_PORTS-1:0]          legal;
  logic [NUM_PORTS-1:0][PW-1:0]  pend;
  logic                          gnt_err_q;

  // A grant counts only if it is one-hot and lands on a requesting port;
  // otherwise the whole vector is discarded for the cycle.
  always_comb begin
    legal_any = $onehot(gnt_i) && ((gnt_i & ~req_o) == '0);
    legal     = legal_any ? gnt_i : '0;
    gnt_bad   = (gnt_i != '0) && !legal_any;
  end

  // Sticky illegal-grant flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt_err_q <= 1'b0;
    else        gnt_err_q <= gnt_err_q | gnt_bad;
  end
  assign gnt_err_o = gnt_err_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    arb_req_shim_port #(
      .MAX_PEND(MAX_PEND), .STARVE_LIMIT(STARVE_LIMIT), .PW(PW)
    ) u_port (
      .clk(clk), .rst_n(rst_n),
      .push_i(push_i[i]), .legal_i(legal[i]),
      .req_o(req_o[i]), .done_o(done_o[i]), .starve_o(starve_o[i]),
      .ovf_o(ovf_o[i]), .pend_o(pend[i])
    );

    a_req: assert property (@(posedge clk) disable iff (!rst_n)
      req_o[i] == (pend[i] != '0));
    a_pend: assert property (@(posedge clk) disable iff (!rst_n)
      pend[i] <= PW'(MAX_PEND));
    a_done: assert property (@(posedge clk) disable iff (!rst_n)
      done_o[i] |-> ($past(rst_n) && $past(legal[i]) && $past(req_o[i])));
  end

  a_done1: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_o));
  a_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) |-> ((($past(ovf_o) & ~ovf_o) == '0) && !($past(gnt_err_o) && !gnt_err_o)));
endmodule

// File: tb/tb_arb_req_shim.sv
// Randomized + directed bench for arb_req_shim with a queue scoreboard.
module tb_arb_req_shim;
  localparam int NP = 4;
  localparam int MP = 3;
  localparam int SL = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NP-1:0] push_i = '0, gnt_i = '0;
  logic [NP-1:0] req_o, done_o, starve_o, ovf_o;
  logic gnt_err_o;

  arb_req_shim #(.NUM_PORTS(NP), .MAX_PEND(MP), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .push_i(push_i), .gnt_i(gnt_i),
    .req_o(req_o), .done_o(done_o), .starve_o(starve_o), .ovf_o(ovf_o),
    .gnt_err_o(gnt_err_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0] req, done, starve, ovf;
    logic err;
  } exp_t;

  exp_t q[$];
  int errs = 0, checks = 0;

  // reference model state
  int m_pend[NP], m_wait[NP];
  logic [NP-1:0] m_ovf;
  logic m_err;

  task automatic chk(input string nm, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] m_req();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = (m_pend[i] > 0);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NP; i++) begin m_pend[i] = 0; m_wait[i] = 0; end
    m_ovf = '0; m_err = 1'b0;
  endtask

  // One cycle: drive at negedge, predict post-edge outputs, enqueue, advance.
  task automatic step(input logic [NP-1:0] p, input logic [NP-1:0] g);
    logic [NP-1:0] rq, dn, sv;
    bit legal;
    int ones;
    exp_t e;
    push_i = p; gnt_i = g;
    rq = m_req();
    ones = $countones(g);
    legal = (ones == 1) && ((g & ~rq) == '0);
    if (g != '0 && !legal) m_err = 1'b1;
    for (int i = 0; i < NP; i++) begin
      dn[i] = legal && g[i];
      if (dn[i]) begin
        if (!p[i]) m_pend[i]--;
      end else if (p[i]) begin
        if (m_pend[i] < MP) m_pend[i]++;
        else m_ovf[i] = 1'b1;
      end
      if (!rq[i] || dn[i]) m_wait[i] = 0;
      else if (m_wait[i] < 255) m_wait[i]++;
      sv[i] = (m_wait[i] >= SL);
    end
    e.req = m_req(); e.done = dn; e.starve = sv; e.ovf = m_ovf; e.err = m_err;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("req", req_o, e.req);
      chk("done", done_o, e.done);
      chk("starve", starve_o, e.starve);
      chk("ovf", ovf_o, e.ovf);
      chk("gnt_err", {{(NP-1){1'b0}}, gnt_err_o}, {{(NP-1){1'b0}}, e.err});
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_req"}, req_o, '0);
    chk({nm, "_done"}, done_o, '0);
    chk({nm, "_starve"}, starve_o, '0);
    chk({nm, "_ovf"}, ovf_o, '0);
    chk({nm, "_err"}, {{(NP-1){1'b0}}, gnt_err_o}, '0);
  endtask

  // Mid-traffic reset: outputs must clear at once, before any clock edge.
  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0; push_i = '0; gnt_i = '0;
    #1 check_zero("rst_async");
    m_reset();
    z = '0;
    q.push_back(z);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] p, g, rq;
    int mode, k;
    m_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // push port0, grant two cycles later
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0001);
    step(4'b0000, 4'b0000);
    // four pushes on port1 -> overflow
    repeat (4) step(4'b0010, 4'b0000);
    // port2 starvation then one legal grant
    step(4'b0100, 4'b0000);
    repeat (9) step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0100);
    step(4'b0000, 4'b0000);
    // illegal grants: multi-hot, and grant on idle port
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0011);
    step(4'b0000, 4'b0100);
    // fill port0 then push+grant same cycle at full
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0000);
    do_reset();

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      p = NP'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) p = NP'($urandom);
      rq = m_req();
      mode = $urandom_range(0, 9);
      g = '0;
      if (mode >= 3 && mode <= 6 && rq != '0) begin
        do k = $urandom_range(0, NP-1); while (!rq[k]);
        g[k] = 1'b1;
      end else if (mode == 7) begin
        g[$urandom_range(0, NP-1)] = 1'b1;
      end else if (mode == 8) begin
        g = NP'($urandom);
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(p, g);
    end

    push_i = '0; gnt_i = '0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/arb_req_shim.md
ARB_REQ_SHIM -- requirements
Module: arb_req_shim

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, number of client ports facing a one-hot fixed-priority arbiter.
REQ-002 The block SHALL have parameter MAX_PEND, default 3, maximum outstanding requests held per port (1..15).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, wait cycles after which a port is flagged starved (1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately, deassertion is synchronous to clk.
REQ-006 push_i  input  NUM_PORTS  per-port one-cycle pulse: client enqueues one request.
REQ-007 gnt_i  input  NUM_PORTS  grant vector from arbiter, expected one-hot or zero.
REQ-008 req_o  output  NUM_PORTS  request vector to arbiter; bit i high while port i has pending requests.
REQ-009 done_o  output  NUM_PORTS  per-port one-cycle pulse: one request of that port was granted.
REQ-010 starve_o  output  NUM_PORTS  per-port level: port waited at least STARVE_LIMIT cycles without grant.
REQ-011 ovf_o  output  NUM_PORTS  per-port sticky flag: a push was dropped because the port was full.
REQ-012 gnt_err_o  output  1  sticky flag: illegal grant observed.

Function
REQ-013 Each port SHALL hold a pending counter pend[i], width ceil(log2(MAX_PEND+1)), range 0..MAX_PEND.
REQ-014 req_o[i] SHALL be registered-state derived: req_o[i] = (pend[i] != 0); no combinational path from push_i or gnt_i to req_o.
REQ-015 A grant on port i SHALL be legal only when gnt_i is one-hot and req_o[i] is high in the same cycle.
REQ-016 Legal grant on port i in cycle N SHALL decrement pend[i] at edge N+1 and assert done_o[i] for exactly cycle N+1.
REQ-017 push_i[i] in cycle N with pend[i] < MAX_PEND and no legal grant on i SHALL increment pend[i] at edge N+1; req_o[i] rises in cycle N+1 if pend[i] was 0.
REQ-018 Simultaneous push_i[i] and legal grant on i SHALL leave pend[i] unchanged and still pulse done_o[i]; this SHALL NOT set ovf_o even when pend[i] == MAX_PEND.
REQ-019 push_i[i] with pend[i] == MAX_PEND and no legal grant on i SHALL drop the push and set ovf_o[i] at N+1, sticky until reset.
REQ-020 gnt_i with more than one bit set, or gnt_i[i] high while req_o[i] low, SHALL set gnt_err_o at N+1 (sticky), and the whole gnt_i vector SHALL be ignored that cycle (no decrement, no done_o).
REQ-021 Each port SHALL hold a wait counter wait[i], 8 bits, saturating at 255.
REQ-022 wait[i] SHALL increment each cycle req_o[i] is high without a legal grant on i; SHALL clear to 0 on a legal grant on i or when req_o[i] is low.
REQ-023 starve_o[i] SHALL equal (wait[i] >= STARVE_LIMIT), derived from registered state only.
REQ-024 Per-port state SHALL be independent; operations on one port SHALL NOT affect another except via gnt_i legality.

Reset
REQ-025 While reset is low: pend, wait = 0; req_o, done_o, starve_o, ovf_o = 0; gnt_err_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard all pending requests without producing done_o pulses.
REQ-027 First push_i sampled is at the first rising edge with reset high.

Verification
REQ-028 Assertions: req_o[i] == (pend[i]!=0); done_o at most one bit set; done_o[i] implies req_o[i] and legal gnt_i[i] previous cycle; pend[i] <= MAX_PEND; ovf_o and gnt_err_o never fall while reset high.
REQ-029 Scenario: push_i=0001 at cycle 0, gnt_i=0001 at cycle 2 -> req_o=0001 cycles 1-2, done_o=0001 cycle 3, req_o=0000 cycle 3.
REQ-030 Scenario: 4 pushes on port 1, no grant (MAX_PEND=3) -> pend[1]=3, ovf_o=0010 after 4th push, req_o[1]=1.
REQ-031 Scenario: port 2 requesting, gnt_i held 0000 for 8 cycles -> starve_o[2] rises in cycle 9 after req_o rise; one legal grant -> starve_o[2]=0 next cycle.
REQ-032 Scenario: req_o=0011, gnt_i=0011 -> gnt_err_o=1 next cycle, pend unchanged, done_o=0000; gnt_i=0100 with req_o[2]=0 -> same.
REQ-033 Scenario: pend[0]=3, push_i[0] and gnt_i=0001 same cycle -> pend[0]=3, done_o=0001, ovf_o[0]=0; then reset low for 1 cycle mid-traffic -> all outputs 0 immediately.
